cdb_multi_arbiter: RTL and testbench
====================================

// Module: cdb_multi_arbiter
// PURPOSE
//  Parametrised common-data-bus arbiter between the functional-unit result buses and the CDB data lanes.
//  Each FU pushes {data, addr, RB index} through a valid/ready handshake into a private result FIFO.
//  A round-robin arbiter then broadcasts up to CDB_LANES results per cycle to the reorder buffer and the RSs.
//  Adds multi-lane grant, per-FU buffering, back-pressure, flush and contention statistics.
// PARAMETERS
//  FU_NUM      8   number of functional-unit result ports
//  CDB_LANES   2   results broadcast per cycle (1..FU_NUM)
//  WORD_SIZE   32  data / address width
//  RB_INDEX    4   reorder-buffer tag width
//  HOLD_DEPTH  2   entries per FU result FIFO (>=1)
//  FU_INDEX    $clog2(FU_NUM)  FU id width (derived)
// PORTS
//  clk          in   1                     clock, rising edge
//  reset        in   1                     asynchronous, active-high
//  flush        in   1                     sync; discard all buffered results (mispredict)
//  fu_valid     in   FU_NUM                FU i presents a result
//  fu_ready     out  FU_NUM                FU i FIFO can accept
//  fu_data      in   FU_NUM*WORD_SIZE      result data, FU i in slice i
//  fu_addr      in   FU_NUM*WORD_SIZE      store address (0 for non-stores)
//  fu_rb_index  in   FU_NUM*RB_INDEX       destination RB entry
//  cdb_valid    out  CDB_LANES             lane k carries a result
//  cdb_data     out  CDB_LANES*WORD_SIZE   broadcast data
//  cdb_addr     out  CDB_LANES*WORD_SIZE   broadcast address
//  cdb_rb_index out  CDB_LANES*RB_INDEX    broadcast RB tag
//  cdb_fu       out  CDB_LANES*FU_INDEX    source FU of lane k
//  stall_cnt    out  16                    saturating count of contention cycles
// BEHAVIOUR
//  - Reset (async): FIFOs empty, rr_ptr=0, all cdb_* = 0, stall_cnt=0; fu_ready forced 0 while reset is high.
//  - Accept: push at posedge when fu_valid[i] & fu_ready[i].
//    fu_ready[i] = (count_i < HOLD_DEPTH); it depends on count only, with no combinational path from fu_valid or the grants.
//    A full FIFO popping this cycle still shows ready=0.
//  - Arbitration (comb., on FIFO heads): scan FU indices rr_ptr, rr_ptr+1, ... mod FU_NUM; the first CDB_LANES non-empty FIFOs win.
//    The first winner goes to lane 0, the next to lane 1, and so on. Winners pop at the same posedge.
//  - CDB outputs are registered: they load at the posedge of the pop and hold for exactly one cycle.
//    Unused lanes: valid=0, data/addr/rb_index/fu = 0.
//  - Latency: a result accepted at edge E is on the CDB after edge E+1 if uncontended (2-cycle fu_valid->cdb_valid).
//  - rr_ptr <= (highest-priority-order last winner)+1 mod FU_NUM; unchanged if there is no winner.
//  - Ordering: per-FU FIFO order is preserved; no ordering guarantee across FUs.
//  - stall_cnt += 1 (saturate at 16'hFFFF) each cycle in which more than CDB_LANES FIFOs are non-empty.
//  - flush: at its posedge, all FIFOs are emptied, pushes in that cycle are dropped, and cdb_valid <= 0. rr_ptr and stall_cnt are kept.
//  - flush together with reset: reset dominates.
//  - Reset mid-operation: buffered results are lost; there is no partial broadcast.
//  - Pointer wrap: the FIFO read/write pointers wrap mod HOLD_DEPTH; count ranges 0..HOLD_DEPTH.
// STRUCTURE
//  - Shared package/include (parameters.v): WORD_SIZE, RB_INDEX, FU_NUM, FU_INDEX.
//  - Sub-module cdb_result_fifo (one per FU, generate loop): clk, reset, flush, push, pop, din, dout, empty, full.
//  - Top level: rotate-and-select grant function, lane output registers, rr_ptr, stall_cnt.
// TESTING
//  1. Reset mid-traffic: raise reset with 3 FIFOs holding results -> all cdb_valid=0, stall_cnt=0, fu_ready=0 during reset, all FIFOs empty after release.
//  2. Single result (FU_NUM=8, CDB_LANES=2): FU3 pushes data=0xDEAD, rb=5 at edge 1 -> after edge 2, lane0 valid with fu=3, data=0xDEAD, rb=5; lane1 valid=0.
//  3. Contention + round robin: FU0, FU2, FU5 push together at edge 1 with rr_ptr=0 -> edge 2: lanes carry FU0, FU2, rr_ptr=3; edge 3: lane0 = FU5; stall_cnt=1.
//  4. Wrap-around: rr_ptr=6, FU7 and FU1 pending -> lane0 = FU7, lane1 = FU1, rr_ptr=2.
//  5. Back-pressure: HOLD_DEPTH=2, FU4 pushes 4 results while FUs 0-3 saturate the CDB -> fu_ready[4]=0 after 2 pushes; FU4 results broadcast in push order once FUs 0-3 stop; no loss or duplication.
//  6. Flush: 5 pending results, flush pulsed for one cycle with FU6 pushing -> next cycle all cdb_valid=0, FU6 result never broadcast, fu_ready all 1.

Source files
------------

// File: rtl/cdb_multi_arbiter_pkg.sv
// Shared widths, sizing constants and the buffered-result record for the CDB arbiter.
// All arbiter files import this package so that FU count, lane count and FIFO depth stay in one place.
package cdb_multi_arbiter_pkg;

  localparam int FU_NUM     = 8;
  localparam int CDB_LANES  = 2;
  localparam int WORD_SIZE  = 32;
  localparam int RB_INDEX   = 4;
  localparam int HOLD_DEPTH = 2;
  localparam int FU_INDEX   = $clog2(FU_NUM);

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] addr;
    logic [RB_INDEX-1:0]  rbIndex;
  } cdbEntry_t;

  // Increment modulo m, used for the round-robin pointer.
  function automatic int wrapInc(input int v, input int m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_multi_arbiter_fifo.sv
// Per-FU result FIFO: a small circular buffer holding results until the arbiter grants them a lane.
// Flush empties it and drops any push arriving in the same cycle.
module cdb_multi_arbiter_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_dout   = r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full & ~i_flush;
  assign w_doPop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= ptrInc(r_wrPtr);
      if (w_doPop)  r_rdPtr <= ptrInc(r_rdPtr);
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_multi_arbiter.sv
// Common-data-bus arbiter: buffers each FU result privately, then broadcasts up to CDB_LANES
// FIFO heads per cycle chosen round-robin, with registered lane outputs and a contention counter.
module cdb_multi_arbiter
  import cdb_multi_arbiter_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_flush,
  input  logic [FU_NUM-1:0]               i_fu_valid,
  output logic [FU_NUM-1:0]               o_fu_ready,
  input  logic [FU_NUM*WORD_SIZE-1:0]     i_fu_data,
  input  logic [FU_NUM*WORD_SIZE-1:0]     i_fu_addr,
  input  logic [FU_NUM*RB_INDEX-1:0]      i_fu_rb_index,
  output logic [CDB_LANES-1:0]            o_cdb_valid,
  output logic [CDB_LANES*WORD_SIZE-1:0]  o_cdb_data,
  output logic [CDB_LANES*WORD_SIZE-1:0]  o_cdb_addr,
  output logic [CDB_LANES*RB_INDEX-1:0]   o_cdb_rb_index,
  output logic [CDB_LANES*FU_INDEX-1:0]   o_cdb_fu,
  output logic [15:0]                     o_stall_cnt
);

  cdbEntry_t            w_din       [FU_NUM];
  cdbEntry_t            w_head      [FU_NUM];
  cdbEntry_t            w_laneEntry [CDB_LANES];
  logic [FU_INDEX-1:0]  w_laneFu    [CDB_LANES];
  logic [CDB_LANES-1:0] w_laneUsed;
  logic [FU_NUM-1:0]    w_empty;
  logic [FU_NUM-1:0]    w_full;
  logic [FU_NUM-1:0]    w_push;
  logic [FU_NUM-1:0]    w_pop;
  logic [FU_INDEX-1:0]  w_nextPtr;
  logic                 w_contended;

  logic [FU_INDEX-1:0]            r_rrPtr;
  logic [15:0]                    r_stallCnt;
  logic [CDB_LANES-1:0]           r_cdbValid;
  logic [CDB_LANES*WORD_SIZE-1:0] r_cdbData;
  logic [CDB_LANES*WORD_SIZE-1:0] r_cdbAddr;
  logic [CDB_LANES*RB_INDEX-1:0]  r_cdbRb;
  logic [CDB_LANES*FU_INDEX-1:0]  r_cdbFu;

  // Ready comes from FIFO occupancy alone, so a full FIFO popping this cycle still refuses.
  assign o_fu_ready = ~w_full & {FU_NUM{~i_reset}};

  for (genvar g = 0; g < FU_NUM; g++) begin : gFifo
    assign w_din[g] = '{data:    i_fu_data[g*WORD_SIZE +: WORD_SIZE],
                        addr:    i_fu_addr[g*WORD_SIZE +: WORD_SIZE],
                        rbIndex: i_fu_rb_index[g*RB_INDEX +: RB_INDEX]};
    assign w_push[g] = i_fu_valid[g] & o_fu_ready[g];

    cdb_multi_arbiter_fifo #(
      .WIDTH ($bits(cdbEntry_t)),
      .DEPTH (HOLD_DEPTH)
    ) uFifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_flush),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (w_din[g]),
      .o_dout  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  // Walk FUs starting at the round-robin pointer; the first non-empty ones fill lanes in order.
  always_comb begin
    int idx;
    int n;
    w_pop       = '0;
    w_laneUsed  = '0;
    w_laneFu    = '{default: '0};
    w_laneEntry = '{default: '0};
    w_nextPtr   = r_rrPtr;
    idx         = 0;
    n           = 0;
    for (int off = 0; off < FU_NUM; off++) begin
      idx = int'(r_rrPtr) + off;
      if (idx >= FU_NUM) idx = idx - FU_NUM;
      if (!w_empty[idx] && n < CDB_LANES) begin
        w_pop[idx]     = 1'b1;
        w_laneUsed[n]  = 1'b1;
        w_laneFu[n]    = FU_INDEX'(idx);
        w_laneEntry[n] = w_head[idx];
        w_nextPtr      = FU_INDEX'(wrapInc(idx, FU_NUM));
        n              = n + 1;
      end
    end
  end

  assign w_contended = ($countones(~w_empty) > CDB_LANES);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rrPtr    <= '0;
      r_stallCnt <= '0;
      r_cdbValid <= '0;
      r_cdbData  <= '0;
      r_cdbAddr  <= '0;
      r_cdbRb    <= '0;
      r_cdbFu    <= '0;
    end else begin
      if (w_contended && r_stallCnt != 16'hFFFF) r_stallCnt <= r_stallCnt + 16'd1;
      if (i_flush) begin
        r_cdbValid <= '0;
        r_cdbData  <= '0;
        r_cdbAddr  <= '0;
        r_cdbRb    <= '0;
        r_cdbFu    <= '0;
      end else begin
        r_rrPtr    <= w_nextPtr;
        r_cdbValid <= w_laneUsed;
        for (int k = 0; k < CDB_LANES; k++) begin
          r_cdbData[k*WORD_SIZE +: WORD_SIZE] <= w_laneEntry[k].data;
          r_cdbAddr[k*WORD_SIZE +: WORD_SIZE] <= w_laneEntry[k].addr;
          r_cdbRb[k*RB_INDEX +: RB_INDEX]     <= w_laneEntry[k].rbIndex;
          r_cdbFu[k*FU_INDEX +: FU_INDEX]     <= w_laneFu[k];
        end
      end
    end
  end

  assign o_cdb_valid    = r_cdbValid;
  assign o_cdb_data     = r_cdbData;
  assign o_cdb_addr     = r_cdbAddr;
  assign o_cdb_rb_index = r_cdbRb;
  assign o_cdb_fu       = r_cdbFu;
  assign o_stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_cdb_multi_arbiter.sv
// Directed bench for cdb_multi_arbiter: reset, single result, contention, wrap-around,
// back-pressure with an ordering scoreboard, and flush.
module tb_cdb_multi_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [7:0]   fuValid;
  logic [7:0]   fuReady;
  logic [255:0] fuData;
  logic [255:0] fuAddr;
  logic [31:0]  fuRb;
  logic [1:0]   cdbValid;
  logic [63:0]  cdbData;
  logic [63:0]  cdbAddr;
  logic [7:0]   cdbRb;
  logic [5:0]   cdbFu;
  logic [15:0]  stallCnt;

  int testsRun = 0;
  int testsFailed = 0;

  cdb_multi_arbiter dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_flush        (flush),
    .i_fu_valid     (fuValid),
    .o_fu_ready     (fuReady),
    .i_fu_data      (fuData),
    .i_fu_addr      (fuAddr),
    .i_fu_rb_index  (fuRb),
    .o_cdb_valid    (cdbValid),
    .o_cdb_data     (cdbData),
    .o_cdb_addr     (cdbAddr),
    .o_cdb_rb_index (cdbRb),
    .o_cdb_fu       (cdbFu),
    .o_stall_cnt    (stallCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    fuValid = '0;
    fuData  = '0;
    fuAddr  = '0;
    fuRb    = '0;
  endtask

  task automatic applyStimulus(input int fu, input logic [31:0] data, input logic [31:0] addr,
                               input logic [3:0] rb);
    fuValid[fu]          = 1'b1;
    fuData[fu*32 +: 32]  = data;
    fuAddr[fu*32 +: 32]  = addr;
    fuRb[fu*4 +: 4]      = rb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] laneData(input int k);
    return cdbData[k*32 +: 32];
  endfunction

  function automatic logic [31:0] laneFu(input int k);
    return {29'd0, cdbFu[k*3 +: 3]};
  endfunction

  task automatic doReset();
    clearInputs();
    flush = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [31:0] sbQ [8][$];
  logic [7:0]  accepted;
  int          seqNo [8];
  int          sent4;
  int          fu4Seen;
  int          cyc;
  bit          done;

  initial begin
    flush = 1'b0;
    clearInputs();
    reset = 1'b1;
    #2;
    checkOutput("rst_cdb_valid", {30'd0, cdbValid}, 32'h0);
    checkOutput("rst_stall", {16'd0, stallCnt}, 32'h0);
    checkOutput("rst_ready", {24'd0, fuReady}, 32'h0);
    checkOutput("rst_cdb_data", laneData(0), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", {24'd0, fuReady}, 32'hFF);

    // Single uncontended result from FU3
    applyStimulus(3, 32'hDEAD, 32'h0, 4'd5);
    tick();
    clearInputs();
    checkOutput("single_not_yet", {30'd0, cdbValid}, 32'h0);
    tick();
    checkOutput("single_valid", {30'd0, cdbValid}, 32'h1);
    checkOutput("single_fu", laneFu(0), 32'd3);
    checkOutput("single_data", laneData(0), 32'hDEAD);
    checkOutput("single_rb", {28'd0, cdbRb[3:0]}, 32'd5);
    checkOutput("single_lane1_data", laneData(1), 32'h0);
    tick();
    checkOutput("single_one_cycle", {30'd0, cdbValid}, 32'h0);

    // Contention and round robin from rr_ptr = 0
    doReset();
    applyStimulus(0, 32'hA0, 32'h0, 4'd0);
    applyStimulus(2, 32'hA2, 32'h0, 4'd2);
    applyStimulus(5, 32'hA5, 32'h1000_0005, 4'd5);
    tick();
    clearInputs();
    tick();
    checkOutput("cont_valid", {30'd0, cdbValid}, 32'h3);
    checkOutput("cont_lane0_fu", laneFu(0), 32'd0);
    checkOutput("cont_lane1_fu", laneFu(1), 32'd2);
    checkOutput("cont_lane1_data", laneData(1), 32'hA2);
    tick();
    checkOutput("cont2_valid", {30'd0, cdbValid}, 32'h1);
    checkOutput("cont2_lane0_fu", laneFu(0), 32'd5);
    checkOutput("cont2_lane0_addr", cdbAddr[31:0], 32'h1000_0005);
    checkOutput("cont_stall", {16'd0, stallCnt}, 32'd1);
    tick();

    // Wrap-around: rr_ptr is now 6 with FU7 and FU1 pending
    applyStimulus(1, 32'hB1, 32'h0, 4'd1);
    applyStimulus(7, 32'hB7, 32'h0, 4'd7);
    tick();
    clearInputs();
    tick();
    checkOutput("wrap_lane0_fu", laneFu(0), 32'd7);
    checkOutput("wrap_lane1_fu", laneFu(1), 32'd1);
    checkOutput("wrap_lane0_data", laneData(0), 32'hB7);
    applyStimulus(1, 32'hC1, 32'h0, 4'd1);
    applyStimulus(2, 32'hC2, 32'h0, 4'd2);
    applyStimulus(3, 32'hC3, 32'h0, 4'd3);
    tick();
    clearInputs();
    tick();
    checkOutput("rr2_lane0_fu", laneFu(0), 32'd2);
    checkOutput("rr2_lane1_fu", laneFu(1), 32'd3);
    tick();
    checkOutput("rr2_late_fu", laneFu(0), 32'd1);
    checkOutput("rr2_late_valid", {30'd0, cdbValid}, 32'h1);
    checkOutput("rr2_stall", {16'd0, stallCnt}, 32'd2);
    tick();

    // Reset mid-traffic with three FIFOs holding results
    applyStimulus(0, 32'hE0, 32'h0, 4'd0);
    applyStimulus(1, 32'hE1, 32'h0, 4'd1);
    applyStimulus(2, 32'hE2, 32'h0, 4'd2);
    tick();
    clearInputs();
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", {30'd0, cdbValid}, 32'h0);
    checkOutput("midrst_stall", {16'd0, stallCnt}, 32'h0);
    checkOutput("midrst_ready", {24'd0, fuReady}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    tick();
    checkOutput("midrst_after_valid", {30'd0, cdbValid}, 32'h0);
    checkOutput("midrst_after_ready", {24'd0, fuReady}, 32'hFF);
    tick();
    checkOutput("midrst_after2_valid", {30'd0, cdbValid}, 32'h0);

    // Back-pressure: FU4 pushes 4 results while FUs 0-3 keep the CDB busy
    doReset();
    for (int f = 0; f < 8; f++) seqNo[f] = 0;
    sent4   = 0;
    fu4Seen = 0;
    done    = 1'b0;
    for (cyc = 0; cyc < 300 && !done; cyc++) begin
      clearInputs();
      if (cyc < 20) begin
        for (int f = 0; f < 4; f++)
          applyStimulus(f, 32'h5000_0000 | (f << 8) | seqNo[f], 32'h0, 4'(f));
      end
      if (sent4 < 4) applyStimulus(4, 32'h5000_0400 | sent4, 32'h0, 4'd4);
      accepted = fuValid & fuReady;
      tick();
      for (int f = 0; f < 8; f++) begin
        if (accepted[f]) begin
          sbQ[f].push_back(fuData[f*32 +: 32]);
          seqNo[f]++;
          if (f == 4) sent4++;
        end
      end
      if (cyc == 1) checkOutput("bp_ready4_full", {31'd0, fuReady[4]}, 32'h0);
      for (int k = 0; k < 2; k++) begin
        if (cdbValid[k]) begin
          int f;
          f = int'(cdbFu[k*3 +: 3]);
          if (f == 4) fu4Seen++;
          if (sbQ[f].size() == 0) begin
            checkOutput("bp_spurious", laneData(k), 32'hFFFF_FFFF);
          end else begin
            checkOutput("bp_order", laneData(k), sbQ[f].pop_front());
          end
        end
      end
      done = (cyc >= 20) && (sent4 == 4);
      for (int f = 0; f < 8; f++) if (sbQ[f].size() != 0) done = 1'b0;
    end
    checkOutput("bp_done_in_budget", {31'd0, done}, 32'h1);
    checkOutput("bp_fu4_count", fu4Seen, 32'd4);
    tick();
    checkOutput("bp_idle", {30'd0, cdbValid}, 32'h0);

    // Flush with 5 pending results and FU6 pushing in the flush cycle
    doReset();
    for (int f = 0; f < 5; f++) applyStimulus(f, 32'hD0 + f, 32'h0, 4'(f));
    tick();
    clearInputs();
    flush = 1'b1;
    applyStimulus(6, 32'h6666, 32'h0, 4'd6);
    tick();
    flush = 1'b0;
    clearInputs();
    checkOutput("flush_valid", {30'd0, cdbValid}, 32'h0);
    checkOutput("flush_ready", {24'd0, fuReady}, 32'hFF);
    checkOutput("flush_stall_kept", {16'd0, stallCnt}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("flush_no_bcast", {30'd0, cdbValid}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
